ahb_slave_mux: RTL
==================

// Module: ahb_slave_mux
// PURPOSE
//  Slave-to-master return path of the AHB interconnect, fed by the address decoder's HSEL.
//  - Registers the address-phase slave select into a data-phase select.
//  - Muxes HRDATA/HREADYOUT/HRESP from the selected slave back to the master.
//  - Contains the default slave: two-cycle ERROR for active transfers to unmapped addresses.
// PARAMETERS
//  DATA_WIDTH   32  width of each slave read-data bus and of HRDATA
//  NO_OF_SLAVES 2   number of slaves; width of HSEL, HREADYOUT_S, HRESP_S
// PORTS
//  HCLK         in   1                        AHB clock, all state on rising edge
//  HRESETn      in   1                        async active-low reset
//  HSEL         in   NO_OF_SLAVES             address-phase select from decoder (one-hot or zero)
//  HTRANS       in   2                        address-phase transfer type (00 IDLE,01 BUSY,10 NONSEQ,11 SEQ)
//  HRDATA_S     in   NO_OF_SLAVES*DATA_WIDTH  slave read data, slave i at [i*DATA_WIDTH +: DATA_WIDTH]
//  HREADYOUT_S  in   NO_OF_SLAVES             per-slave HREADYOUT
//  HRESP_S      in   NO_OF_SLAVES             per-slave HRESP (0 OKAY, 1 ERROR)
//  HRDATA       out  DATA_WIDTH               muxed read data to master
//  HREADY       out  1                        muxed ready to master and all slaves
//  HRESP        out  1                        muxed response to master
// BEHAVIOUR
//  - Address phase is accepted on any rising HCLK edge where HREADY=1. On that edge:
//    dsel <= HSEL (lowest set bit wins if >1 set); ddef <= (HSEL==0 && HTRANS[1]).
//  - While HREADY=0, dsel/ddef hold; HSEL/HTRANS are ignored.
//  - Mux is combinational from registered state, with no extra latency:
//    dsel[i]=1 -> HRDATA=slice i, HREADY=HREADYOUT_S[i], HRESP=HRESP_S[i].
//    ddef=1    -> HRDATA=0, HREADY/HRESP from default-slave FSM.
//    neither   -> HRDATA=0, HREADY=1, HRESP=0 (idle data phase, zero wait, OKAY).
//  - IDLE/BUSY to a mapped slave still routes to that slave; the slave returns OKAY.
//  - IDLE/BUSY to an unmapped address: ddef=0, OKAY with zero wait.
//  - Default-slave FSM, states DS_IDLE, DS_ERR1, DS_ERR2:
//    DS_IDLE -> DS_ERR1 on an accepted unmapped NONSEQ/SEQ.
//    DS_ERR1 -> DS_ERR2 unconditionally; outputs HREADY=0, HRESP=1.
//    DS_ERR2 outputs HREADY=1, HRESP=1; -> DS_ERR1 if an unmapped NONSEQ/SEQ is accepted
//      this edge, else -> DS_IDLE.
//    DS_IDLE outputs HREADY=1, HRESP=0 (only visible when ddef=1, which cannot occur in DS_IDLE).
//  - Timing: unmapped address accepted at edge t -> data-phase cycle t+1 ERR1, cycle t+2 ERR2,
//    next address phase accepted at end of t+2.
//  - Back-to-back: a mapped transfer accepted during DS_ERR2 routes to that slave in the next
//    cycle, and the FSM goes to DS_IDLE.
//  - Slave wait states: HREADYOUT_S[i]=0 extends the data phase. dsel holds, and the pipelined
//    address phase is held off by the shared HREADY.
//  - Reset (async assert, sync-released by system): dsel=0, ddef=0, FSM=DS_IDLE;
//    HRDATA=0, HREADY=1, HRESP=0. Reset mid-ERROR or mid-wait aborts the transfer with no
//    residual state.
//  - HSEL index out of range cannot occur; unused high HSEL bits do not exist by construction.
// TESTING
//  1 Reset: HRESETn=0 mid ERR1 -> HREADY=1, HRESP=0, HRDATA=0 immediately; after release,
//    idle bus stays OKAY.
//  2 Mapped read: HSEL=01, HTRANS=10, then slave0 HRDATA_S=0xDEADBEEF with 2 wait cycles ->
//    HREADY=0,0,1 and HRDATA=0xDEADBEEF on the ready cycle, HRESP=0.
//  3 Unmapped NONSEQ: HSEL=00, HTRANS=10 -> next cycle HREADY=0/HRESP=1, following cycle
//    HREADY=1/HRESP=1, then OKAY.
//  4 Unmapped IDLE: HSEL=00, HTRANS=00 -> HREADY=1, HRESP=0, no ERROR cycles.
//  5 Back-to-back: unmapped SEQ, accept slave1 transfer during ERR2 -> ERR sequence completes,
//    next cycle routes slave1 data/HREADYOUT/HRESP; also two consecutive unmapped transfers ->
//    ERR1,ERR2,ERR1,ERR2.
//  6 Slave ERROR passthrough: slave1 drives HRESP_S=10, HREADYOUT_S=01 then 11 ->
//    HRESP=1 both cycles, HREADY=0 then 1.

Source files
------------

// File: rtl/ahb_slave_mux.sv
// ============================================================================
// Module      : ahb_slave_mux
// Description : AHB slave-to-master return path. It registers the
//               address-phase select, muxes the data-phase response and
//               contains the two-cycle ERROR default slave.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module ahb_slave_mux #(
  parameter int DATA_WIDTH   = 32,
  parameter int NO_OF_SLAVES = 2
) (
  input  logic                               HCLK,
  input  logic                               HRESETn,
  input  logic [NO_OF_SLAVES-1:0]            HSEL,
  input  logic [1:0]                         HTRANS,
  input  logic [NO_OF_SLAVES*DATA_WIDTH-1:0] HRDATA_S,
  input  logic [NO_OF_SLAVES-1:0]            HREADYOUT_S,
  input  logic [NO_OF_SLAVES-1:0]            HRESP_S,
  output logic [DATA_WIDTH-1:0]              HRDATA,
  output logic                               HREADY,
  output logic                               HRESP
);

  localparam logic [1:0] DS_IDLE = 2'd0;
  localparam logic [1:0] DS_ERR1 = 2'd1;
  localparam logic [1:0] DS_ERR2 = 2'd2;

  logic [NO_OF_SLAVES-1:0] hsel_lsb;
  logic                    hsel_found;
  logic                    accept;
  logic                    unmapped_active;
  logic                    unused_htrans;

  logic [NO_OF_SLAVES-1:0] dsel_q, dsel_d;
  logic                    ddef_q, ddef_d;
  logic [1:0]              ds_state_q, ds_state_d;
  logic                    def_hready;
  logic                    def_hresp;

  // Only NONSEQ/SEQ matter for the default slave; HTRANS[0] separates IDLE from BUSY.
  assign unused_htrans   = HTRANS[0];
  assign accept          = HREADY;
  assign unmapped_active = (HSEL == '0) && HTRANS[1];

  always_comb begin
    hsel_lsb   = '0;
    hsel_found = 1'b0;
    for (int i = 0; i < NO_OF_SLAVES; i++) begin
      if (HSEL[i] && !hsel_found) begin
        hsel_lsb[i] = 1'b1;
        hsel_found  = 1'b1;
      end
    end
  end

  always_comb begin
    dsel_d = dsel_q;
    ddef_d = ddef_q;
    if (accept) begin
      dsel_d = hsel_lsb;
      ddef_d = unmapped_active;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dsel_q     <= '0;
      ddef_q     <= 1'b0;
      ds_state_q <= DS_IDLE;
    end else begin
      dsel_q     <= dsel_d;
      ddef_q     <= ddef_d;
      ds_state_q <= ds_state_d;
    end
  end

  always_comb begin
    ds_state_d = ds_state_q;
    case (ds_state_q)
      DS_IDLE: if (accept && unmapped_active) ds_state_d = DS_ERR1;
      DS_ERR1: ds_state_d = DS_ERR2;
      DS_ERR2: ds_state_d = (accept && unmapped_active) ? DS_ERR1 : DS_IDLE;
      default: ds_state_d = DS_IDLE;
    endcase
  end

  always_comb begin
    def_hready = 1'b1;
    def_hresp  = 1'b0;
    case (ds_state_q)
      DS_ERR1: begin
        def_hready = 1'b0;
        def_hresp  = 1'b1;
      end
      DS_ERR2: begin
        def_hready = 1'b1;
        def_hresp  = 1'b1;
      end
      default: begin
        def_hready = 1'b1;
        def_hresp  = 1'b0;
      end
    endcase
  end

  // dsel_q is one-hot or zero, so at most one slice is ever routed.
  always_comb begin
    HRDATA = '0;
    HREADY = 1'b1;
    HRESP  = 1'b0;
    if (ddef_q) begin
      HREADY = def_hready;
      HRESP  = def_hresp;
    end else begin
      for (int i = 0; i < NO_OF_SLAVES; i++) begin
        if (dsel_q[i]) begin
          HRDATA = HRDATA_S[i*DATA_WIDTH +: DATA_WIDTH];
          HREADY = HREADYOUT_S[i];
          HRESP  = HRESP_S[i];
        end
      end
    end
  end

endmodule

`default_nettype wire
